// File: rtl/bal_seq_pkg.sv
// Shared types, default channel/threshold constants and the diff saturation
// helper for the balance update sequencer.
package bal_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    W_LFT  = 3'd1,
    W_RGHT = 3'd2,
    W_BATT = 3'd3,
    UPDT   = 3'd4
  } state_t;

  typedef logic [11:0] smpl_t;

  localparam logic [2:0]  LFT_CHNL_D     = 3'd0;
  localparam logic [2:0]  RGHT_CHNL_D    = 3'd4;
  localparam logic [2:0]  BATT_CHNL_D    = 3'd5;
  localparam logic [12:0] MIN_RIDER_WT_D = 13'h0200;
  localparam logic [12:0] WT_HYST_D      = 13'h0040;
  localparam int          TIMEOUT_D      = 1023;

  // Clamp a 13-bit signed difference into the 12-bit signed range.
  function automatic logic signed [11:0] sat12(input logic signed [12:0] d);
    if (d > 13'sd2047)
      return 12'sh7FF;
    else if (d < -13'sd2048)
      return 12'sh800;
    else
      return d[11:0];
  endfunction

endpackage

// File: rtl/bal_seq_tmr.sv
// Conversion watchdog: counts cycles spent waiting on the A2D and flags
// expiry on the TIMEOUT-th consecutive waiting cycle.
module bal_seq_tmr #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt;

  assign expired = en && (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || clr || expired)
      cnt <= '0;
    else if (en)
      cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/bal_update_seq.sv
// Sequences left/right/battery conversions on the shared A2D per pitch sample
// and produces the saturated load-cell diff, hysteretic rider_off and bal_vld.
module bal_update_seq
  import bal_seq_pkg::*;
#(
  parameter logic [2:0]  LFT_CHNL     = LFT_CHNL_D,
  parameter logic [2:0]  RGHT_CHNL    = RGHT_CHNL_D,
  parameter logic [2:0]  BATT_CHNL    = BATT_CHNL_D,
  parameter logic [12:0] MIN_RIDER_WT = MIN_RIDER_WT_D,
  parameter logic [12:0] WT_HYST      = WT_HYST_D,
  parameter int          TIMEOUT      = TIMEOUT_D
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nxt_ptch_vld,
  input  logic        a2d_cnv_cmplt,
  input  logic [11:0] a2d_res,
  output logic        a2d_strt,
  output logic [2:0]  a2d_chnl,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] batt,
  output logic [11:0] ld_cell_diff,
  output logic        rider_off,
  output logic        bal_vld,
  output logic        ovr_err,
  output logic        a2d_err
);

  localparam logic [12:0] RIDER_LO = MIN_RIDER_WT - WT_HYST;
  localparam logic [12:0] RIDER_HI = MIN_RIDER_WT + WT_HYST;

  state_t state, nxt_state;
  logic   strt_nxt, lft_we, rght_we, batt_we, updt, ovr_set, err_set;
  logic   waiting, expired, rider_off_nxt;
  logic [2:0]         chnl_nxt;
  logic signed [12:0] diff;
  logic [12:0]        sum;

  assign waiting = (state == W_LFT) || (state == W_RGHT) || (state == W_BATT);

  bal_seq_tmr #(.TIMEOUT(TIMEOUT)) u_tmr (
    .clk     (clk),
    .rst     (rst),
    .clr     (!waiting || a2d_cnv_cmplt),
    .en      (waiting),
    .expired (expired)
  );

  // Diff and sum are formed from the already-latched lft/rght values, so the
  // update can be registered on the same edge that captures the battery.
  assign diff = $signed({1'b0, lft_ld}) - $signed({1'b0, rght_ld});
  assign sum  = {1'b0, lft_ld} + {1'b0, rght_ld};

  always_comb begin
    rider_off_nxt = rider_off;
    if (sum < RIDER_LO)
      rider_off_nxt = 1'b1;
    else if (sum > RIDER_HI)
      rider_off_nxt = 1'b0;
  end

  always_comb begin
    nxt_state = state;
    strt_nxt  = 1'b0;
    chnl_nxt  = a2d_chnl;
    lft_we    = 1'b0;
    rght_we   = 1'b0;
    batt_we   = 1'b0;
    updt      = 1'b0;
    err_set   = 1'b0;
    ovr_set   = nxt_ptch_vld && (state != IDLE);
    case (state)
      IDLE: if (nxt_ptch_vld) begin
        strt_nxt  = 1'b1;
        chnl_nxt  = LFT_CHNL;
        nxt_state = W_LFT;
      end
      W_LFT: if (a2d_cnv_cmplt) begin
        lft_we    = 1'b1;
        strt_nxt  = 1'b1;
        chnl_nxt  = RGHT_CHNL;
        nxt_state = W_RGHT;
      end else if (expired) begin
        err_set   = 1'b1;
        nxt_state = IDLE;
      end
      W_RGHT: if (a2d_cnv_cmplt) begin
        rght_we   = 1'b1;
        strt_nxt  = 1'b1;
        chnl_nxt  = BATT_CHNL;
        nxt_state = W_BATT;
      end else if (expired) begin
        err_set   = 1'b1;
        nxt_state = IDLE;
      end
      W_BATT: if (a2d_cnv_cmplt) begin
        batt_we   = 1'b1;
        updt      = 1'b1;
        nxt_state = UPDT;
      end else if (expired) begin
        err_set   = 1'b1;
        nxt_state = IDLE;
      end
      UPDT:    nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= nxt_state;
  end

  // Output register stage: bal_vld and the new diff/rider_off appear together.
  always_ff @(posedge clk) begin
    if (rst) begin
      a2d_strt     <= 1'b0;
      a2d_chnl     <= LFT_CHNL;
      lft_ld       <= '0;
      rght_ld      <= '0;
      batt         <= '0;
      ld_cell_diff <= '0;
      rider_off    <= 1'b1;
      bal_vld      <= 1'b0;
      ovr_err      <= 1'b0;
      a2d_err      <= 1'b0;
    end else begin
      a2d_strt <= strt_nxt;
      a2d_chnl <= chnl_nxt;
      bal_vld  <= updt;
      ovr_err  <= ovr_err | ovr_set;
      a2d_err  <= a2d_err | err_set;
      if (lft_we)  lft_ld  <= a2d_res;
      if (rght_we) rght_ld <= a2d_res;
      if (batt_we) batt    <= a2d_res;
      if (updt) begin
        ld_cell_diff <= sat12(diff);
        rider_off    <= rider_off_nxt;
      end
    end
  end

endmodule

// File: tb/tb_bal_update_seq.sv
// Directed plus randomized bench for bal_update_seq against a plain-arithmetic
// model of the latched loads, saturated diff, rider hysteresis and error flags.
module tb_bal_update_seq;

  localparam int TIMEOUT = 1023;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        nxt_ptch_vld = 1'b0;
  logic        a2d_cnv_cmplt = 1'b0;
  logic [11:0] a2d_res = '0;
  logic        a2d_strt, rider_off, bal_vld, ovr_err, a2d_err;
  logic [2:0]  a2d_chnl;
  logic [11:0] lft_ld, rght_ld, batt, ld_cell_diff;

  int n_assert = 0;
  int n_fail   = 0;
  int strt_cnt = 0;
  int vld_cnt  = 0;

  logic [11:0] m_lft, m_rght, m_batt, m_diff;
  logic        m_ro, m_ovr, m_err;

  bal_update_seq dut (
    .clk           (clk),
    .rst           (rst),
    .nxt_ptch_vld  (nxt_ptch_vld),
    .a2d_cnv_cmplt (a2d_cnv_cmplt),
    .a2d_res       (a2d_res),
    .a2d_strt      (a2d_strt),
    .a2d_chnl      (a2d_chnl),
    .lft_ld        (lft_ld),
    .rght_ld       (rght_ld),
    .batt          (batt),
    .ld_cell_diff  (ld_cell_diff),
    .rider_off     (rider_off),
    .bal_vld       (bal_vld),
    .ovr_err       (ovr_err),
    .a2d_err       (a2d_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (a2d_strt) strt_cnt++;
    if (bal_vld)  vld_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] model_diff(input logic [11:0] l, input logic [11:0] r);
    int d;
    d = int'(l) - int'(r);
    if (d > 2047)  d = 2047;
    if (d < -2048) d = -2048;
    return 12'(d);
  endfunction

  task automatic model_reset();
    m_lft = '0; m_rght = '0; m_batt = '0; m_diff = '0;
    m_ro = 1'b1; m_ovr = 1'b0; m_err = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_lft"},  lft_ld,       m_lft);
    check({tag, "_rght"}, rght_ld,      m_rght);
    check({tag, "_batt"}, batt,         m_batt);
    check({tag, "_diff"}, ld_cell_diff, m_diff);
    check({tag, "_ro"},   rider_off,    m_ro);
    check({tag, "_ovr"},  ovr_err,      m_ovr);
    check({tag, "_err"},  a2d_err,      m_err);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    model_reset();
    check("rst_strt", a2d_strt, 1'b0);
    check("rst_chnl", a2d_chnl, 3'd0);
    check("rst_vld",  bal_vld,  1'b0);
    check_outputs("rst");
    rst = 1'b0;
  endtask

  // Wait for the request on channel ch, then answer it after dly cycles.
  task automatic conv(input logic [2:0] ch, input logic [11:0] val, input int dly, input bit ovr);
    int n = 0;
    while (!a2d_strt && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("strt_seen", a2d_strt, 1'b1);
    check("chnl", a2d_chnl, ch);
    for (int i = 0; i < dly; i++) begin
      nxt_ptch_vld = ovr && (i == 0);
      @(negedge clk);
    end
    nxt_ptch_vld = 1'b0;
    a2d_res = val;
    a2d_cnv_cmplt = 1'b1;
    @(negedge clk);
    a2d_cnv_cmplt = 1'b0;
  endtask

  task automatic run_txn(input logic [11:0] l, input logic [11:0] r, input logic [11:0] b,
                         input int dly, input bit ovr_r, input bit ovr_u);
    int s0, v0, sum;
    s0 = strt_cnt;
    v0 = vld_cnt;
    nxt_ptch_vld = 1'b1;
    @(negedge clk);
    nxt_ptch_vld = 1'b0;
    conv(3'd0, l, dly, 1'b0);
    conv(3'd4, r, dly, ovr_r);
    conv(3'd5, b, dly, 1'b0);
    m_lft = l; m_rght = r; m_batt = b;
    m_diff = model_diff(l, r);
    sum = int'(l) + int'(r);
    if (sum < 'h200 - 'h40)      m_ro = 1'b1;
    else if (sum > 'h200 + 'h40) m_ro = 1'b0;
    m_ovr = m_ovr | ovr_r | ovr_u;
    check("vld_hi", bal_vld, 1'b1);
    nxt_ptch_vld = ovr_u;
    @(negedge clk);
    nxt_ptch_vld = 1'b0;
    check("vld_lo", bal_vld, 1'b0);
    repeat (2) @(negedge clk);
    check("vld_cnt",  vld_cnt,  v0 + 1);
    check("strt_cnt", strt_cnt, s0 + 3);
    check_outputs("txn");
  endtask

  initial begin
    int s0, v0;
    logic [11:0] l, r, old_rght;
    model_reset();
    do_reset();

    // Normal sequence
    run_txn(12'h600, 12'h400, 12'hA00, 20, 1'b0, 1'b0);
    check("norm_diff", ld_cell_diff, 12'h200);
    check("norm_ro",   rider_off,    1'b0);
    check("norm_batt", batt,         12'hA00);

    // Saturation
    run_txn(12'hFFF, 12'h000, 12'h123, 3, 1'b0, 1'b0);
    check("sat_pos", ld_cell_diff, 12'h7FF);
    run_txn(12'h000, 12'hFFF, 12'h456, 3, 1'b0, 1'b0);
    check("sat_neg", ld_cell_diff, 12'h800);

    // Hysteresis from rider_off=0
    run_txn(12'h0F8, 12'h0F8, 12'h111, 2, 1'b0, 1'b0);
    check("hyst_1f0", rider_off, 1'b0);
    run_txn(12'h080, 12'h080, 12'h111, 2, 1'b0, 1'b0);
    check("hyst_100", rider_off, 1'b1);
    run_txn(12'h118, 12'h118, 12'h111, 2, 1'b0, 1'b0);
    check("hyst_230", rider_off, 1'b1);
    run_txn(12'h180, 12'h180, 12'h111, 2, 1'b0, 1'b0);
    check("hyst_300", rider_off, 1'b0);

    // Randomized transactions, half with small weights to exercise hysteresis
    for (int t = 0; t < 24; t++) begin
      if (t % 2 == 0) begin
        l = 12'($urandom_range(0, 'h180));
        r = 12'($urandom_range(0, 'h180));
      end else begin
        l = 12'($urandom);
        r = 12'($urandom);
      end
      run_txn(l, r, 12'($urandom), int'($urandom_range(1, 8)), 1'b0, 1'b0);
    end

    // Overrun during W_RGHT
    do_reset();
    run_txn(12'h300, 12'h100, 12'h222, 4, 1'b1, 1'b0);
    check("ovr_rght", ovr_err, 1'b1);

    // Overrun in the UPDT cycle only
    do_reset();
    run_txn(12'h100, 12'h300, 12'h333, 4, 1'b0, 1'b1);
    check("ovr_updt", ovr_err, 1'b1);

    // Timeout while waiting on the right load cell
    old_rght = m_rght;
    s0 = strt_cnt;
    v0 = vld_cnt;
    nxt_ptch_vld = 1'b1;
    @(negedge clk);
    nxt_ptch_vld = 1'b0;
    conv(3'd0, 12'h5A5, 2, 1'b0);
    repeat (TIMEOUT - 10) @(negedge clk);
    check("to_early", a2d_err, 1'b0);
    repeat (20) @(negedge clk);
    check("to_err",  a2d_err, 1'b1);
    check("to_vld",  vld_cnt, v0);
    check("to_strt", strt_cnt, s0 + 2);
    check("to_lft",  lft_ld, 12'h5A5);
    check("to_rght", rght_ld, old_rght);
    m_lft = 12'h5A5;
    m_err = 1'b1;
    run_txn(12'h400, 12'h200, 12'h789, 3, 1'b0, 1'b0);

    // Reset in W_BATT, then a late cmplt
    do_reset();
    nxt_ptch_vld = 1'b1;
    @(negedge clk);
    nxt_ptch_vld = 1'b0;
    conv(3'd0, 12'h700, 2, 1'b0);
    conv(3'd4, 12'h100, 2, 1'b0);
    repeat (3) @(negedge clk);
    s0 = strt_cnt;
    v0 = vld_cnt;
    rst = 1'b1;
    @(negedge clk);
    model_reset();
    check("mid_strt", a2d_strt, 1'b0);
    check("mid_chnl", a2d_chnl, 3'd0);
    check("mid_vld",  bal_vld,  1'b0);
    check_outputs("mid");
    rst = 1'b0;
    a2d_res = 12'hABC;
    a2d_cnv_cmplt = 1'b1;
    @(negedge clk);
    a2d_cnv_cmplt = 1'b0;
    repeat (3) @(negedge clk);
    check("late_vld",  vld_cnt,  v0);
    check("late_strt", strt_cnt, s0);
    check_outputs("late");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bal_update_seq.md
Name: bal_update_seq

Overview:
Sequencer feeding balance_cntrl's vld/ld_cell_diff/rider_off inputs. On each new pitch sample from the inertial interface it shares the single A2D interface across three conversions in a fixed order: left load cell, right load cell, battery. It then computes a saturated load-cell difference and hysteretic rider-off, and issues one vld strobe per completed update. It also detects A2D timeouts and sample overruns.

Parameters:
LFT_CHNL, 3'd0, A2D channel for left load cell
RGHT_CHNL, 3'd4, A2D channel for right load cell
BATT_CHNL, 3'd5, A2D channel for battery
MIN_RIDER_WT, 13'h0200, rider-present threshold on lft+rght
WT_HYST, 13'h0040, hysteresis half-band around MIN_RIDER_WT
TIMEOUT, 1023, max cycles waiting for one conversion

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock; synchronous, active-high
nxt_ptch_vld  in  1  1-cycle pulse: new ptch available
a2d_cnv_cmplt  in  1  1-cycle pulse: conversion done
a2d_res  in  12  conversion result, valid with a2d_cnv_cmplt
a2d_strt  out  1  1-cycle conversion request
a2d_chnl  out  3  channel select, registered, stable from a2d_strt until cmplt
lft_ld  out  12  latched left load cell
rght_ld  out  12  latched right load cell
batt  out  12  latched battery reading
ld_cell_diff  out  12  signed saturated lft_ld - rght_ld
rider_off  out  1  rider absent (hysteretic)
bal_vld  out  1  1-cycle strobe to balance_cntrl vld
ovr_err  out  1  sticky: sample arrived while busy
a2d_err  out  1  sticky: conversion timeout

Behaviour:
- Reset values, all registered outputs: a2d_strt=0, a2d_chnl=LFT_CHNL, lft_ld/rght_ld/batt/ld_cell_diff=0, rider_off=1, bal_vld=0, ovr_err=0, a2d_err=0. State=IDLE, timeout counter=0.
- FSM: IDLE -> W_LFT -> W_RGHT -> W_BATT -> UPDT -> IDLE.
- IDLE: on nxt_ptch_vld, assert a2d_strt for one cycle with a2d_chnl=LFT_CHNL and go to W_LFT. a2d_cnv_cmplt in IDLE or UPDT is ignored.
- W_x: on a2d_cnv_cmplt, latch a2d_res into that channel's register and clear the counter.
  - From W_LFT and W_RGHT, pulse a2d_strt with the next channel in the same cycle.
  - From W_BATT, go to UPDT.
- UPDT (one cycle): register ld_cell_diff and rider_off from the latched values, assert bal_vld in that same cycle, then return to IDLE. Latency: bal_vld is high exactly 1 cycle after the cycle in which the battery cmplt arrives.
- Diff: 13-bit signed lft_ld - rght_ld, saturated to 12-bit signed (max 12'h7FF, min 12'h800).
- Rider-off uses sum = lft_ld + rght_ld (13-bit, no wrap):
  - set when sum < MIN_RIDER_WT - WT_HYST;
  - clear when sum > MIN_RIDER_WT + WT_HYST;
  - otherwise hold.
- Timeout: the counter increments every cycle in W_x. If it reaches TIMEOUT, set a2d_err, return to IDLE, and issue no bal_vld. Latched values keep their old contents, including any partial update.
- Overrun: nxt_ptch_vld while the state is not IDLE is dropped and sets ovr_err. This includes the UPDT cycle.
- Sticky errors clear only on rst.
- rst asserted mid-sequence returns all state to reset values on the next edge. No a2d_strt or bal_vld is issued in that cycle.

Decomposition:
- Package bal_seq_pkg holds:
  - state enum typedef;
  - default channel constants;
  - 12-bit sample typedef;
  - saturation helper function.
- One natural sub-module, bal_seq_tmr: the timeout counter with clear/enable/expired.

Test Plan:
- Normal: pulse nxt_ptch_vld; return results 12'h600, 12'h400, 12'hA00 after 20 cycles each. Expect:
  - a2d_chnl sequence 0, 4, 5, one a2d_strt per channel;
  - ld_cell_diff=12'h200, rider_off=0, batt=12'hA00;
  - a single bal_vld one cycle after the third cmplt.
- Saturation: results lft=12'hFFF, rght=12'h000 -> ld_cell_diff=12'h7FF. Then lft=12'h000, rght=12'hFFF -> ld_cell_diff=12'h800.
- Hysteresis, starting from rider_off=0:
  - sum 12'h1F0 -> rider_off stays 0;
  - sum 12'h100 -> rider_off=1;
  - sum 12'h230 -> stays 1;
  - sum 12'h300 -> rider_off=0.
- Overrun: second nxt_ptch_vld during W_RGHT, and another in the UPDT cycle. Expect ovr_err=1, only one bal_vld, sequence otherwise unaffected.
- Timeout: withhold cmplt in W_RGHT for TIMEOUT cycles. Expect:
  - a2d_err=1, return to IDLE, no bal_vld;
  - lft_ld updated, rght_ld unchanged;
  - next nxt_ptch_vld starts a fresh sequence at LFT_CHNL.
- Reset mid-op: assert rst in W_BATT. Expect all outputs at reset values next cycle (rider_off=1), and a late cmplt ignored.
